pl_mem_access: RTL and testbench

PL_MEM_ACCESS -- requirements
Module: pl_mem_access

---
 rtl/pl_mem_access.sv | 148 ++++++++++++++
 tb/tb_pl_mem_access.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pl_mem_access.sv
// MEM-stage load/store bus access: one bus transaction per access, pipeline stall, timeout.
// Optional MISALIGN_TRAP_EN: trap misaligned h/w accesses instead of forcing alignment.
//
// state  | meaning
// IDLE   | waiting for an access; bus fields latched on leaving
// ACCESS | mem_req high, waiting for mem_ready or timeout
// DONE   | one-cycle release; pipeline advances, stall dropped
module pl_mem_access #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state, state_nx;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;

  logic        access, size_half, size_word, misalign_trap, start;
  logic        complete, timeout;
  logic [1:0]  lane;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign access    = MemWriteM | (ResultSrcM == 2'b01);
  assign size_half = (funct3M[1:0] == 2'b01);
  assign size_word = funct3M[1];

  // Lane is always size-aligned; with the trap enabled misaligned accesses never start.
  assign lane = size_word ? 2'b00 : (size_half ? {ALUResultM[1], 1'b0} : ALUResultM[1:0]);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned    = (size_half & ALUResultM[0]) | (size_word & (|ALUResultM[1:0]));
  assign misalign_trap = (state == S_IDLE) & access & misaligned;
  assign MisalignM     = misalign_trap & ~reset;
`else
  assign misalign_trap = 1'b0;
  assign MisalignM     = 1'b0;
`endif

  assign start    = (state == S_IDLE) & access & ~misalign_trap;
  assign complete = (state == S_ACCESS) & mem_ready;
  assign timeout  = (state == S_ACCESS) & ~mem_ready & (wait_cnt == WAIT_LAST);
  assign mem_req  = (state == S_ACCESS);

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = WriteDataM;
    if (!size_word && !size_half) begin
      wdata_nx = {4{WriteDataM[7:0]}};
      if (MemWriteM) be_nx = 4'b0001 << lane;
    end else if (size_half) begin
      wdata_nx = {2{WriteDataM[15:0]}};
      if (MemWriteM) be_nx = 4'b0011 << lane;
    end
  end

  always_comb begin
    state_nx = state;
    StallM   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ACCESS;
          StallM   = 1'b1;
        end
      end
      S_ACCESS: begin
        StallM = 1'b1;
        if (complete || timeout) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      lane_q    <= '0;
      f3_q      <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      state   <= state_nx;
      BusErrM <= timeout;
      if (start) begin
        wait_cnt  <= '0;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[31:2], 2'b00};
        mem_wdata <= wdata_nx;
        mem_be    <= be_nx;
        lane_q    <= lane;
        f3_q      <= funct3M;
      end else if ((state == S_ACCESS) && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (complete && !mem_we) ReadDataM <= load_ext;
    end
  end

endmodule

// File: tb/tb_pl_mem_access.sv
// Scoreboard bench for pl_mem_access: driver queues expected access results, a
// negedge monitor checks bus fields, stall length, load data and BusErrM on each release.
module tb_pl_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [2:0]  funct3M = '0;
  logic [1:0]  ResultSrcM = '0;
  logic        MemWriteM = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ReadDataM;
  logic        StallM, BusErrM, MisalignM;

  pl_mem_access #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  be;
    logic        we;
    logic        buserr;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // monitor
  int          stall_cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
      req_seen  = 1'b0;
    end else begin
      if (mem_req && !req_seen) begin
        req_seen  = 1'b1;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_be    = mem_be;
        cap_we    = mem_we;
      end
      if (StallM) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: stall %0d with no queued access", stall_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("req_seen",   {31'd0, req_seen}, 32'd1);
          chk("mem_addr",   cap_addr, mon_e.addr);
          chk("mem_wdata",  cap_wdata, mon_e.wdata);
          chk("mem_be",     {28'd0, cap_be}, {28'd0, mon_e.be});
          chk("mem_we",     {31'd0, cap_we}, {31'd0, mon_e.we});
          chk("stall_len",  stall_cnt, mon_e.stall);
          chk("ReadDataM",  ReadDataM, mon_e.rd);
          chk("BusErrM",    {31'd0, BusErrM}, {31'd0, mon_e.buserr});
        end
        stall_cnt = 0;
        req_seen  = 1'b0;
      end else if (BusErrM) begin
        errors++;
        $display("FAIL buserr_stray: BusErrM=1 expected 0 outside release cycle");
      end
    end
  end

  task automatic clear_inputs();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    funct3M    = 3'b000;
    ALUResultM = '0;
    WriteDataM = '0;
  endtask

  // delay < 0: never answer; otherwise mem_ready on ACCESS cycle delay+1
  task automatic run_access(input logic we, input logic [1:0] rsrc, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input int delay,
                            input logic [31:0] rdata, input logic [31:0] e_addr,
                            input logic [31:0] e_wdata, input logic [3:0] e_be,
                            input logic [31:0] e_rd);
    exp_t e;
    int   k;
    e.addr   = e_addr;
    e.wdata  = e_wdata;
    e.be     = e_be;
    e.we     = we;
    e.rd     = e_rd;
    e.buserr = (delay < 0);
    e.stall  = (delay < 0) ? 16 : delay + 2;
    exp_q.push_back(e);
    MemWriteM  = we;
    ResultSrcM = rsrc;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    @(posedge clk); #1;
    k = 0;
    while (StallM && k < 300) begin
      mem_ready = (k == delay);
      mem_rdata = rdata;
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL access_bound: StallM still 1 after %0d cycles, expected release", k);
    end
    // DONE cycle: a stray ready with junk data must be ignored
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'd0, mem_req, mem_we, StallM, BusErrM, MisalignM}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rd",   ReadDataM, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //          we    rsrc   f3      addr          wdata         dly rdata          e_addr        e_wdata       e_be     e_rd
    run_access(1'b1, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0,         32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 32'h0000_0000);
    run_access(1'b0, 2'b01, 3'b000, 32'h0000_2001, 32'h0,         0, 32'h0000_8000, 32'h0000_2000, 32'h0,         4'b1111, 32'hFFFF_FF80);
    run_access(1'b0, 2'b01, 3'b100, 32'h0000_2001, 32'h0,         0, 32'h0000_8000, 32'h0000_2000, 32'h0,         4'b1111, 32'h0000_0080);
    run_access(1'b0, 2'b01, 3'b101, 32'h0000_2002, 32'h0,         4, 32'hBEEF_0000, 32'h0000_2000, 32'h0,         4'b1111, 32'h0000_BEEF);
    run_access(1'b0, 2'b01, 3'b010, 32'h0000_2004, 32'h0,        -1, 32'h1111_1111, 32'h0000_2004, 32'h0,         4'b1111, 32'h0000_BEEF);
    run_access(1'b1, 2'b00, 3'b001, 32'h0000_1006, 32'h1234_5678, 2, 32'h0,         32'h0000_1004, 32'h5678_5678, 4'b1100, 32'h0000_BEEF);
    run_access(1'b1, 2'b00, 3'b010, 32'h0000_100C, 32'hCAFE_F00D, 1, 32'h0,         32'h0000_100C, 32'hCAFE_F00D, 4'b1111, 32'h0000_BEEF);
    run_access(1'b1, 2'b01, 3'b000, 32'h0000_1001, 32'h0000_005A, 0, 32'hFFFF_FFFF, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0010, 32'h0000_BEEF);
    run_access(1'b0, 2'b01, 3'b001, 32'h0000_2002, 32'h0,         0, 32'h8001_0000, 32'h0000_2000, 32'h0,         4'b1111, 32'hFFFF_8001);
    run_access(1'b0, 2'b01, 3'b010, 32'h0000_2008, 32'h0,        14, 32'h0BAD_F00D, 32'h0000_2008, 32'h0,         4'b1111, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
    ResultSrcM = 2'b01;
    funct3M    = 3'b010;
    ALUResultM = 32'h0000_3002;
    #1;
    chk("misalign_flag",  {31'd0, MisalignM}, 32'd1);
    chk("misalign_stall", {31'd0, StallM}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_req) seen = 1'b1;
    end
    chk("misalign_no_req", {31'd0, seen}, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
`else
    seen = 1'b0;
    run_access(1'b0, 2'b01, 3'b010, 32'h0000_3002, 32'h0,         0, 32'h1234_5678, 32'h0000_3000, 32'h0,         4'b1111, 32'h1234_5678);
    run_access(1'b0, 2'b01, 3'b101, 32'h0000_2003, 32'h0,         0, 32'hBEEF_1234, 32'h0000_2000, 32'h0,         4'b1111, 32'h0000_BEEF);
    chk("misalign_tied", {31'd0, MisalignM}, 32'd0);
`endif

    // reset in the 2nd ACCESS cycle
    ResultSrcM = 2'b01;
    funct3M    = 3'b010;
    ALUResultM = 32'h0000_4000;
    @(posedge clk); #1;
    chk("rstmid_req_a1", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("rstmid_req_a2", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_ctrl",  {27'd0, mem_req, mem_we, StallM, BusErrM, MisalignM}, 32'd0);
    chk("rstmid_addr",  mem_addr, 32'd0);
    chk("rstmid_wdata", mem_wdata, 32'd0);
    chk("rstmid_be",    {28'd0, mem_be}, 32'd0);
    chk("rstmid_rd",    ReadDataM, 32'd0);
    @(posedge clk); #1;

    run_access(1'b0, 2'b01, 3'b100, 32'h0000_2003, 32'h0,         0, 32'h7F00_0000, 32'h0000_2000, 32'h0,         4'b1111, 32'h0000_007F);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
